// File: rtl/tile_line_renderer.sv
// Tile-map renderer: prefetches one tile row into a double-buffered line store, displays from the front bank.
// Latency: 1 cycle from pixel_x/pixel_y/pixel_read to registered R/G/B; one registered map request outstanding.
// Backpressure: map stalls via mapa_valid; a swap before the fetch completes sets sticky underrun. Option: TILE_RENDERER_GRID_EN.
module tile_line_renderer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BLOCK_BITS    = 3,
  parameter int COLOR_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_read,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic [COLOR_BITS-1:0] R,
  output logic [COLOR_BITS-1:0] G,
  output logic [COLOR_BITS-1:0] B,
  output logic [9:0]            mapa_x,
  output logic [9:0]            mapa_y,
  output logic                  mapa_read,
  input  logic                  mapa_valid,
  input  logic [COLOR_BITS-1:0] mapa_R,
  input  logic [COLOR_BITS-1:0] mapa_G,
  input  logic [COLOR_BITS-1:0] mapa_B,
  output logic                  underrun
);

  localparam int TILES_X = SCREEN_WIDTH >> BLOCK_BITS;
  localparam int TILES_Y = SCREEN_HEIGHT >> BLOCK_BITS;
  localparam int CW      = 3 * COLOR_BITS;
  localparam int IW      = (TILES_X > 1) ? $clog2(TILES_X) : 1;

  localparam logic [9:0] LAST_COL = 10'(TILES_X - 1);
  localparam logic [9:0] NUM_ROWS = 10'(TILES_Y);
  localparam logic [9:0] X_LIMIT  = 10'(SCREEN_WIDTH);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  col, col_nxt;
  logic [9:0]  row, row_nxt;
  logic        front, front_nxt;
  logic        underrun_nxt;
  logic        read_nxt;
  logic        wr_en;
  logic        pixel_read_d;
  logic        swap;
  logic        grid_hit;
  logic [9:0]  next_row;
  logic [IW-1:0] wr_idx, rd_idx;

  // Two banks of one tile row each; bank 'front' is displayed, the other is filled.
  logic [CW-1:0] line_mem [2][TILES_X];

  assign swap     = pixel_read & ~pixel_read_d & (pixel_y[BLOCK_BITS-1:0] == '0);
  assign next_row = (pixel_y >> BLOCK_BITS) + 10'd1;
  assign wr_idx   = IW'(col);
  assign rd_idx   = IW'(pixel_x >> BLOCK_BITS);
  assign mapa_x   = col;
  assign mapa_y   = row;

`ifdef TILE_RENDERER_GRID_EN
  assign grid_hit = (pixel_x[BLOCK_BITS-1:0] == '0) | (pixel_y[BLOCK_BITS-1:0] == '0);
`else
  assign grid_hit = 1'b0;
`endif

  // State register: FSM, fetch position, bank select, sticky underrun and registered request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      front        <= 1'b0;
      underrun     <= 1'b0;
      mapa_read    <= 1'b0;
      pixel_read_d <= 1'b0;
    end else begin
      state        <= state_nxt;
      col          <= col_nxt;
      row          <= row_nxt;
      front        <= front_nxt;
      underrun     <= underrun_nxt;
      mapa_read    <= read_nxt;
      pixel_read_d <= pixel_read;
    end
  end

  // Next state: frame_start beats a swap; a transfer landing on either event cycle is dropped,
  // so the write never targets the bank that becomes visible.
  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    front_nxt    = front;
    underrun_nxt = underrun;
    wr_en        = 1'b0;
    if (frame_start) begin
      state_nxt = REQ;
      col_nxt   = '0;
      row_nxt   = '0;
    end else if (swap) begin
      front_nxt = ~front;
      if (state != DONE) underrun_nxt = 1'b1;
      if (next_row < NUM_ROWS) begin
        state_nxt = REQ;
        col_nxt   = '0;
        row_nxt   = next_row;
      end else begin
        state_nxt = IDLE;
      end
    end else if (state == REQ && mapa_valid) begin
      wr_en = 1'b1;
      if (col == LAST_COL) state_nxt = DONE;
      else                 col_nxt   = col + 10'd1;
    end
  end

  // Output decode: request is high whenever the next state is fetching.
  always_comb begin
    read_nxt = (state_nxt == REQ);
  end

  // Back-bank write of the accepted tile colour.
  always_ff @(posedge clk) begin
    if (wr_en) line_mem[~front][wr_idx] <= {mapa_R, mapa_G, mapa_B};
  end

  // Pixel path: read the bank that is front after this cycle, so a swap shows the new row at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {R, G, B} <= '0;
    end else if (!pixel_read || pixel_x >= X_LIMIT) begin
      {R, G, B} <= '0;
    end else if (grid_hit) begin
      {R, G, B} <= '1;
    end else begin
      {R, G, B} <= line_mem[front_nxt][rd_idx];
    end
  end

endmodule

// File: tb/tb_tile_line_renderer.sv
// Bench for tile_line_renderer: random pixel traffic and map latency against an event-level model.
// The model tracks which tile colour sits in each bank entry and predicts RGB, request and underrun every cycle.
// Map memory returns R=col[1:0], G=row[1:0], B=col[3:2].
module tb_tile_line_renderer;

  localparam int W    = 640;
  localparam int H    = 480;
  localparam int BB   = 3;
  localparam int CB   = 2;
  localparam int TILE = 1 << BB;
  localparam int TX   = W / TILE;
  localparam int TY   = H / TILE;
  localparam int ACT  = 24;
  localparam int BLK  = 12;

`ifdef TILE_RENDERER_GRID_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          pixel_read = 1'b0;
  logic [9:0]    pixel_x = '0;
  logic [9:0]    pixel_y = '0;
  logic [CB-1:0] R, G, B;
  logic [9:0]    mapa_x, mapa_y;
  logic          mapa_read;
  logic          mapa_valid = 1'b0;
  logic [CB-1:0] mapa_R, mapa_G, mapa_B;
  logic          underrun;

  tile_line_renderer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pixel_read(pixel_read), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .R(R), .G(G), .B(B),
    .mapa_x(mapa_x), .mapa_y(mapa_y), .mapa_read(mapa_read), .mapa_valid(mapa_valid),
    .mapa_R(mapa_R), .mapa_G(mapa_G), .mapa_B(mapa_B),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Map memory contents as a function of tile address.
  assign mapa_R = mapa_x[1:0];
  assign mapa_G = mapa_y[1:0];
  assign mapa_B = mapa_x[3:2];

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int tile_rgb(input int c, input int r);
    return ((c % 4) << 4) | ((r % 4) << 2) | ((c / 4) % 4);
  endfunction

  // Map responder: zero-wait, random wait, or a forced stall window.
  int cyc = 0;
  int stall_until = 0;
  int map_mode = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (cyc < stall_until)  mapa_valid = 1'b0;
    else if (map_mode == 0) mapa_valid = 1'b1;
    else                    mapa_valid = 1'($urandom_range(0, 1));
  end

  int xfer_cnt = 0;
  always @(posedge clk) begin
    if (frame_start) xfer_cnt <= 0;
    else if (mapa_read && mapa_valid) xfer_cnt <= xfer_cnt + 1;
  end

  // Reference model: bank[b][i] holds the expected colour code or -1 when unknown.
  int bank[2][TX];
  int m_front, m_col, m_row, nf, tx, nr;
  bit m_fetch, m_done, m_under, m_prev, sw, xf;
  int e_rgb, e_x, e_y;
  bit e_known, e_read, e_under;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_front = 0; m_col = 0; m_row = 0;
      m_fetch = 0; m_done = 0; m_under = 0; m_prev = 0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < TX; i++) bank[b][i] = -1;
      e_rgb = 0; e_known = 1;
    end else begin
      sw = pixel_read && !m_prev && (int'(pixel_y) % TILE == 0);
      xf = m_fetch && mapa_valid;
      nf = (sw && !frame_start) ? 1 - m_front : m_front;
      if (!pixel_read || int'(pixel_x) >= W) begin
        e_known = 1; e_rgb = 0;
      end else if (GRID && (int'(pixel_x) % TILE == 0 || int'(pixel_y) % TILE == 0)) begin
        e_known = 1; e_rgb = 63;
      end else begin
        tx = int'(pixel_x) / TILE;
        e_rgb = bank[nf][tx];
        e_known = (e_rgb >= 0);
      end
      if (frame_start) begin
        m_fetch = 1; m_done = 0; m_row = 0; m_col = 0;
      end else if (sw) begin
        if (!m_done) m_under = 1;
        m_front = nf;
        m_done = 0;
        nr = int'(pixel_y) / TILE + 1;
        if (nr < TY) begin m_fetch = 1; m_row = nr; m_col = 0; end
        else m_fetch = 0;
      end else if (xf) begin
        bank[1 - m_front][m_col] = tile_rgb(m_col, m_row);
        m_col++;
        if (m_col == TX) begin m_fetch = 0; m_done = 1; end
      end
      m_prev = pixel_read;
    end
    e_read = m_fetch; e_x = m_col; e_y = m_row; e_under = m_under;
  end

  // Cycle-by-cycle compare of every registered output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      if (e_known) chk("rgb", int'({R, G, B}), e_rgb);
      chk("mapa_read", int'(mapa_read), int'(e_read));
      if (e_read || reset) chk("mapa_xy", int'({mapa_y, mapa_x}), e_y * 1024 + e_x);
      chk("underrun", int'(underrun), int'(e_under));
    end
  end

  logic [5:0] c0, c1;
  logic       cr0;
  logic [9:0] cy0;

  task automatic start_frame(input int blank);
    @(negedge clk);
    frame_start = 1'b1; pixel_read = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (blank) @(negedge clk);
  endtask

  task automatic do_line(input int y, input int x0, input int x1);
    for (int i = 0; i < ACT; i++) begin
      @(negedge clk);
      pixel_read = 1'b1;
      pixel_y = 10'(y);
      if (i == 0)      pixel_x = 10'(x0);
      else if (i == 1) pixel_x = 10'(x1);
      else             pixel_x = 10'($urandom_range(0, 700));
      if (i == 1) begin #2; c0 = {R, G, B}; cr0 = mapa_read; cy0 = mapa_y; end
      if (i == 2) begin #2; c1 = {R, G, B}; end
    end
    for (int i = 0; i < BLK; i++) begin
      @(negedge clk);
      pixel_read = 1'b0;
      pixel_x = 10'($urandom_range(0, 1023));
    end
  endtask

  initial begin
    int x0, x1;
    #1 reset = 1'b1; chk_on = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Frame 1: zero-wait map, full frame.
    map_mode = 0;
    start_frame(100);
    #2;
    chk("fetch_count", xfer_cnt, 80);
    chk("read_after_fetch", int'(mapa_read), 0);
    chk("row0_y", int'(mapa_y), 0);
    for (int y = 0; y < H; y++) begin
      x0 = (y == 0) ? 17 : (y == 5) ? 16 : (y == 8) ? 9 : int'($urandom_range(0, 639));
      x1 = (y == 5) ? 17 : int'($urandom_range(0, 639));
      do_line(y, x0, x1);
      if (y == 0) begin
        #2;
        chk("l0_x17_R", int'(c0[5:4]), GRID ? 3 : 2);
        chk("l0_x17_G", int'(c0[3:2]), GRID ? 3 : 0);
        chk("l0_row1_read", int'(cr0), 1);
        chk("l0_row1_y", int'(cy0), 1);
      end
      if (y == 5) begin
        #2;
        chk("px16_5", int'(c0), GRID ? 63 : 32);
        chk("px17_5", int'(c1), 32);
      end
      if (y == 8) begin
        #2;
        chk("l8_x9_R", int'(c0[5:4]), GRID ? 3 : 1);
        chk("l8_x9_G", int'(c0[3:2]), GRID ? 3 : 1);
        chk("l8_underrun", int'(underrun), 0);
      end
    end
    #2;
    chk("idle_after_row59", int'(mapa_read), 0);
    chk("blank_rgb", int'({R, G, B}), 0);

    // Frame 2: random map latency, then a long stall during the row-1 fetch.
    map_mode = 1;
    start_frame(400);
    #2;
    chk("f2_row0_done", int'(mapa_read), 0);
    chk("f2_no_underrun", int'(underrun), 0);
    stall_until = cyc + 1000;
    for (int y = 0; y < 40; y++) begin
      do_line(y, int'($urandom_range(0, 700)), int'($urandom_range(0, 700)));
      if (y == 8) begin #2; chk("stall_underrun", int'(underrun), 1); end
    end

    // Frame 3: underrun survives frame_start; reset mid-fetch clears everything at once.
    start_frame(20);
    #2;
    chk("underrun_sticky", int'(underrun), 1);
    chk("refetch_read", int'(mapa_read), 1);
    chk("refetch_row", int'(mapa_y), 0);
    reset = 1'b1;
    #1;
    chk("rst_read_async", int'(mapa_read), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_rgb", int'({R, G, B}), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
